pipe_stage_chain: RTL

- Parametrised elastic pipeline register chain. Generalises the fixed IF/ID and ID/EX pipe registers, with their per-register valid bits, into STAGES stages of WIDTH-bit payload.
- Adds per-stage stall, per-stage flush (squash younger), valid/ready backpressure, bubble collapsing and an occupancy count.
- Used between CPU pipeline stages and in the memory-side request path.
- Stage 0 is youngest (nearest input); stage STAGES-1 is oldest (drives output).

---
 rtl/pipe_stage_chain.sv | 129 ++++++++++++
 1 files changed

// File: rtl/pipe_stage_chain.sv
// pipe_stage_chain
//   Elastic chain of STAGES pipeline registers, each WIDTH bits wide with its
//   own valid bit. Stage 0 is the youngest (fed from in_*), stage STAGES-1 the
//   oldest (drives out_*). Supports per-stage stall, per-stage flush that
//   squashes the flushed stage and everything younger, valid/ready
//   backpressure with bubble collapsing, and a registered occupancy count.
//
// Ports
//   clk          rising-edge clock
//   reset        asynchronous, active-high reset
//   in_valid     producer offers in_data
//   in_data      payload entering stage 0
//   in_ready     chain accepts in_data this cycle
//   stall_vec    bit k holds stage k's contents
//   flush_vec    bit k squashes stages 0..k
//   out_valid    oldest stage presents valid data
//   out_data     contents of stage STAGES-1
//   out_ready    consumer accepts out_data
//   stage_valid  registered valid bit per stage
//   stage_data   stage k at bits [k*WIDTH +: WIDTH]
//   occupancy    number of set stage_valid bits
module pipe_stage_chain #(
    parameter int WIDTH  = 16,
    parameter int STAGES = 4,
    parameter int CNTW   = $clog2(STAGES + 1)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      in_valid,
    input  logic [WIDTH-1:0]          in_data,
    output logic                      in_ready,
    input  logic [STAGES-1:0]         stall_vec,
    input  logic [STAGES-1:0]         flush_vec,
    output logic                      out_valid,
    output logic [WIDTH-1:0]          out_data,
    input  logic                      out_ready,
    output logic [STAGES-1:0]         stage_valid,
    output logic [STAGES*WIDTH-1:0]   stage_data,
    output logic [CNTW-1:0]           occupancy
);

    logic [STAGES-1:0] r_valid;
    logic [WIDTH-1:0]  r_data [STAGES];
    logic [CNTW-1:0]   r_occ;

    // w_kill and w_rdy carry one extra top entry so the oldest stage sees
    // "no flush from above" and out_ready respectively.
    logic [STAGES:0]   w_kill;
    logic [STAGES:0]   w_rdy;
    logic [STAGES-1:0] w_v;
    logic [STAGES-1:0] w_send;
    logic [STAGES-1:0] w_recv;
    logic [STAGES-1:0] w_valid_nxt;
    logic [CNTW-1:0]   w_occ_nxt;
    logic              w_accept;

    // Kill and ready both propagate from the oldest stage toward the youngest,
    // so the loop walks the index downward.
    always_comb begin
        w_kill         = '0;
        w_rdy          = '0;
        w_v            = '0;
        w_send         = '0;
        w_rdy[STAGES]  = out_ready;
        for (int unsigned i = 0; i < STAGES; i++) begin
            w_kill[STAGES-1-i] = flush_vec[STAGES-1-i] | w_kill[STAGES-i];
            w_v[STAGES-1-i]    = r_valid[STAGES-1-i] & ~w_kill[STAGES-1-i];
            w_send[STAGES-1-i] = w_v[STAGES-1-i] & ~stall_vec[STAGES-1-i]
                               & w_rdy[STAGES-i];
            w_rdy[STAGES-1-i]  = ~w_v[STAGES-1-i]
                               | (~stall_vec[STAGES-1-i] & w_rdy[STAGES-i]);
        end
    end

    // Any flush blocks input: the youngest stage is always among those killed.
    always_comb begin
        in_ready  = w_rdy[0] & ~(|flush_vec);
        w_accept  = in_valid & in_ready;
        out_valid = w_v[STAGES-1] & ~stall_vec[STAGES-1];
        out_data  = r_data[STAGES-1];
    end

    // A stage refilled in the same cycle it sends stays valid, which is what
    // lets a full chain move one item per cycle.
    always_comb begin
        w_recv    = '0;
        w_recv[0] = w_accept;
        for (int unsigned k = 1; k < STAGES; k++) begin
            w_recv[k] = w_send[k-1];
        end
        w_valid_nxt = '0;
        w_occ_nxt   = '0;
        for (int unsigned k = 0; k < STAGES; k++) begin
            w_valid_nxt[k] = w_recv[k] | (r_valid[k] & ~w_kill[k] & ~w_send[k]);
            w_occ_nxt      = w_occ_nxt + CNTW'(w_valid_nxt[k]);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_valid <= '0;
            r_occ   <= '0;
            for (int unsigned k = 0; k < STAGES; k++) begin
                r_data[k] <= '0;
            end
        end else begin
            r_valid <= w_valid_nxt;
            r_occ   <= w_occ_nxt;
            if (w_recv[0]) begin
                r_data[0] <= in_data;
            end
            for (int unsigned k = 1; k < STAGES; k++) begin
                if (w_recv[k]) begin
                    r_data[k] <= r_data[k-1];
                end
            end
        end
    end

    always_comb begin
        stage_data = '0;
        for (int unsigned k = 0; k < STAGES; k++) begin
            stage_data[k*WIDTH +: WIDTH] = r_data[k];
        end
        stage_valid = r_valid;
        occupancy   = r_occ;
    end

endmodule
